// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a small {pc, instruction} FIFO.
// Owns the fetch PC and drives the instruction memory every cycle. The
// memory returns its word combinationally, and that word is captured together
// with the PC of the fetch. Decode drains the FIFO over a valid/ready
// handshake. A redirect flushes every queued entry and restarts fetch at the
// new, word-aligned PC.
// Optional build macro FETCH_QUEUE_PERF_EN adds the fetch and flush event
// counters fetch_count_o and flush_count_o.
module fetch_queue #(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
  parameter int                DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] imem_addr_o,
  output logic              imem_read_en_o,
  input  logic [DWIDTH-1:0] imem_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       fetch_count_o,
  output logic [31:0]       flush_count_o
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);
  localparam logic [AWIDTH-1:0] PC_STEP = AWIDTH'(4);

  // Control state
  logic [AWIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  // Entry storage; never reset, the count qualifies what is readable
  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Instructions are word aligned, so the low two redirect bits are dropped
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc_i[1:0];

  // Queue status and handshake qualification
  always_comb begin
    full  = (count == CNT_MAX);
    empty = (count == '0);
    // A full queue blocks fetch even if decode pops this cycle (no bypass)
    push  = !rst && !redirect_i && !full;
    // Redirect wins over the handshake: the head shown that cycle is dropped
    pop   = !empty && insn_ready_i && !redirect_i;
  end

  // Memory interface: the address always follows the fetch PC
  always_comb begin
    imem_addr_o    = fetch_pc;
    imem_read_en_o = push;
  end

  // Head presentation, built only from registered state
  always_comb begin
    insn_valid_o = !empty;
    insn_o       = '0;
    pc_o         = '0;
    if (!empty) begin
      insn_o = insn_mem[rd_ptr];
      pc_o   = pc_mem[rd_ptr];
    end
  end

  // Fetch PC, pointers and occupancy; reset beats redirect, redirect beats traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= BASE_ADDR;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_i) begin
      fetch_pc <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_ONE;
        // Wraps modulo 2^AWIDTH, so the last word rolls over to address 0
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Capture the fetched word alongside the PC it came from
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      insn_mem[wr_ptr] <= imem_data_i;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  // Event counters: one per fetched word, one per redirect cycle out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (redirect_i) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end

  assign fetch_count_o = fetch_count;
  assign flush_count_o = flush_count;
`endif

endmodule
